// File: rtl/pipeline_hazard_sequencer_if.sv
// Hazard sequencer connection bundle: Decode/Execute hazard inputs and the
// stall/flush/redirect controls plus performance counters going back to the core.
interface pipeline_hazard_sequencer_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic [REG_AW-1:0] rd_e;
    logic              mem_read_e;
    logic              branch_d;
    logic              for_d;
    logic              jump_d;
    logic              br_resolved_e;
    logic              br_taken_e;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic              pc_redirect;
    logic              busy;
    logic              err_timeout;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output rs1_d, rs2_d, rd_e, mem_read_e, branch_d, for_d, jump_d,
               br_resolved_e, br_taken_e,
        input  stall_f, stall_d, flush_d, flush_e, pc_redirect, busy,
               err_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_d, rs2_d, rd_e, mem_read_e, branch_d, for_d, jump_d,
               br_resolved_e, br_taken_e,
        output stall_f, stall_d, flush_d, flush_e, pc_redirect, busy,
               err_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// Load-use stall and branch/loop resolution sequencer for the 5-stage core,
// with Mealy stall/flush controls and saturating performance counters.
module pipeline_hazard_sequencer #(
    parameter int REG_AW   = 3,
    parameter int LOAD_LAT = 1,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pipeline_hazard_sequencer_if.slave hz
);
    localparam int LD_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;
    localparam int WT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {RUN, LD_STALL, BR_WAIT} state_t;

    state_t            state_reg, state_next;
    logic [LD_W-1:0]   ld_cnt_reg, ld_cnt_next;
    logic [WT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic              err_reg, err_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0]  flush_cnt_reg, flush_cnt_next;
    logic              lu;
    logic              sf, sd, fd, fe, pr;
    logic              sf_g, sd_g, fd_g, fe_g, pr_g;

    // r0 is hard-wired zero, so a load targeting it never creates a dependency
    assign lu = hz.mem_read_e && (hz.rd_e != '0) &&
                ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            ld_cnt_reg    <= '0;
            wait_cnt_reg  <= '0;
            err_reg       <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ld_cnt_reg    <= ld_cnt_next;
            wait_cnt_reg  <= wait_cnt_next;
            err_reg       <= err_next;
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ld_cnt_next   = ld_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        err_next      = err_reg;
        sf            = 1'b0;
        sd            = 1'b0;
        fd            = 1'b0;
        fe            = 1'b0;
        pr            = 1'b0;
        case (state_reg)
            RUN: begin
                if (lu) begin
                    sf = 1'b1;
                    sd = 1'b1;
                    fe = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_next  = LD_STALL;
                        ld_cnt_next = LD_W'(LOAD_LAT - 1);
                    end
                end else if (hz.branch_d || hz.for_d) begin
                    sf            = 1'b1;
                    fd            = 1'b1;
                    state_next    = BR_WAIT;
                    wait_cnt_next = '0;
                end else if (hz.jump_d) begin
                    pr = 1'b1;
                    fd = 1'b1;
                end
            end
            LD_STALL: begin
                sf          = 1'b1;
                sd          = 1'b1;
                fe          = 1'b1;
                ld_cnt_next = ld_cnt_reg - LD_W'(1);
                if (ld_cnt_reg == LD_W'(1)) begin
                    state_next = RUN;
                end
            end
            BR_WAIT: begin
                if (hz.br_resolved_e) begin
                    pr         = hz.br_taken_e;
                    state_next = RUN;
                end else begin
                    sf = 1'b1;
                    fd = 1'b1;
                    // this is the MAX_WAIT-th unresolved cycle: give up and flag it
                    if (wait_cnt_reg == WT_W'(MAX_WAIT - 1)) begin
                        err_next   = 1'b1;
                        state_next = RUN;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WT_W'(1);
                    end
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Outputs are forced low while reset is asserted, even though they are Mealy
    assign sf_g = rst_n & sf;
    assign sd_g = rst_n & sd;
    assign fd_g = rst_n & fd;
    assign fe_g = rst_n & fe;
    assign pr_g = rst_n & pr;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (sf_g && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
        if ((fd_g || fe_g) && (flush_cnt_reg != '1)) begin
            flush_cnt_next = flush_cnt_reg + CNT_W'(1);
        end
    end

    assign hz.stall_f     = sf_g;
    assign hz.stall_d     = sd_g;
    assign hz.flush_d     = fd_g;
    assign hz.flush_e     = fe_g;
    assign hz.pc_redirect = pr_g;
    assign hz.busy        = rst_n & (state_reg != RUN);
    assign hz.err_timeout = rst_n & err_reg;
    assign hz.stall_cnt   = stall_cnt_reg;
    assign hz.flush_cnt   = flush_cnt_reg;
endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Scoreboard bench: one DUT with LOAD_LAT=1/16-bit counters, one with LOAD_LAT=3/2-bit
// counters (to reach saturation); each driven cycle pushes its expected outputs.
module tb_pipeline_hazard_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_sequencer_if #(.REG_AW(3), .CNT_W(16)) hz1 ();
    pipeline_hazard_sequencer_if #(.REG_AW(3), .CNT_W(2))  hz3 ();

    pipeline_hazard_sequencer #(.REG_AW(3), .LOAD_LAT(1), .MAX_WAIT(4), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .hz(hz1)
    );
    pipeline_hazard_sequencer #(.REG_AW(3), .LOAD_LAT(3), .MAX_WAIT(4), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .hz(hz3)
    );

    typedef struct {
        bit         d3;
        string      nm;
        logic [6:0] ctrl;   // {stall_f, stall_d, flush_d, flush_e, pc_redirect, busy, err_timeout}
        int         sc;
        int         fc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic clear_inputs();
        hz1.rs1_d = '0; hz1.rs2_d = '0; hz1.rd_e = '0; hz1.mem_read_e = 1'b0;
        hz1.branch_d = 1'b0; hz1.for_d = 1'b0; hz1.jump_d = 1'b0;
        hz1.br_resolved_e = 1'b0; hz1.br_taken_e = 1'b0;
        hz3.rs1_d = '0; hz3.rs2_d = '0; hz3.rd_e = '0; hz3.mem_read_e = 1'b0;
        hz3.branch_d = 1'b0; hz3.for_d = 1'b0; hz3.jump_d = 1'b0;
        hz3.br_resolved_e = 1'b0; hz3.br_taken_e = 1'b0;
    endtask

    task automatic drive(input bit d3, input string nm, input bit rv,
                         input int rs1, input int rs2, input int rd, input bit mr,
                         input bit br, input bit fr, input bit jp, input bit res, input bit tk,
                         input logic [6:0] ctrl, input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rv;
        clear_inputs();
        if (d3) begin
            hz3.rs1_d = 3'(rs1); hz3.rs2_d = 3'(rs2); hz3.rd_e = 3'(rd);
            hz3.mem_read_e = mr; hz3.branch_d = br; hz3.for_d = fr; hz3.jump_d = jp;
            hz3.br_resolved_e = res; hz3.br_taken_e = tk;
        end else begin
            hz1.rs1_d = 3'(rs1); hz1.rs2_d = 3'(rs2); hz1.rd_e = 3'(rd);
            hz1.mem_read_e = mr; hz1.branch_d = br; hz1.for_d = fr; hz1.jump_d = jp;
            hz1.br_resolved_e = res; hz1.br_taken_e = tk;
        end
        e.d3 = d3; e.nm = nm; e.ctrl = ctrl; e.sc = sc; e.fc = fc;
        q.push_back(e);
    endtask

    // Monitor: every driven cycle presents outputs mid-cycle; pop and compare.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [6:0] act_ctrl;
        int act_sc, act_fc;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.d3) begin
                act_ctrl = {hz3.stall_f, hz3.stall_d, hz3.flush_d, hz3.flush_e,
                            hz3.pc_redirect, hz3.busy, hz3.err_timeout};
                act_sc = int'(hz3.stall_cnt);
                act_fc = int'(hz3.flush_cnt);
            end else begin
                act_ctrl = {hz1.stall_f, hz1.stall_d, hz1.flush_d, hz1.flush_e,
                            hz1.pc_redirect, hz1.busy, hz1.err_timeout};
                act_sc = int'(hz1.stall_cnt);
                act_fc = int'(hz1.flush_cnt);
            end
            total++;
            if (act_ctrl !== e.ctrl) begin
                bad++;
                $display("FAIL %s ctrl: got=%b want=%b", e.nm, act_ctrl, e.ctrl);
            end
            total++;
            if (act_sc != e.sc || act_fc != e.fc) begin
                bad++;
                $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         e.nm, act_sc, act_fc, e.sc, e.fc);
            end
            $display("check %s dut%0d ctrl=%b stall_cnt=%0d flush_cnt=%0d",
                     e.nm, e.d3 ? 3 : 1, act_ctrl, act_sc, act_fc);
        end
    end

    initial begin
        clear_inputs();
        //        d3 name        rv rs1 rs2 rd mr br fr jp rs tk ctrl       sc  fc
        drive(0, "rst_lu_br",   0, 3, 0, 3, 1, 1, 0, 0, 0, 0, 7'b0000000, 0, 0);
        drive(0, "idle0",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0);
        drive(0, "lu_rs1",      1, 3, 0, 3, 1, 0, 0, 0, 0, 0, 7'b1101000, 0, 0);
        drive(0, "after_lu",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 1, 1);
        drive(0, "load_r0",     1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 7'b0000000, 1, 1);
        drive(0, "lu_rs2",      1, 0, 5, 5, 1, 0, 0, 0, 0, 0, 7'b1101000, 1, 1);
        drive(0, "br_accept",   1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7'b1010000, 2, 2);
        drive(0, "br_wait",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1010010, 3, 3);
        drive(0, "br_res_tk",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000110, 4, 4);
        drive(0, "idle1",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 4, 4);
        drive(0, "for_plus_lu", 1, 2, 0, 2, 1, 0, 1, 0, 0, 0, 7'b1101000, 4, 4);
        drive(0, "for_accept",  1, 2, 0, 2, 0, 0, 1, 0, 0, 0, 7'b1010000, 5, 5);
        drive(0, "res_nt_jmp",  1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b0000010, 6, 6);
        drive(0, "jump",        1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0010100, 6, 6);
        drive(0, "res_in_run",  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000000, 6, 7);
        drive(0, "br_to",       1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7'b1010000, 6, 7);
        drive(0, "to_w1",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1010010, 7, 8);
        drive(0, "to_w2",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1010010, 8, 9);
        drive(0, "to_w3",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1010010, 9, 10);
        drive(0, "to_w4",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1010010, 10, 11);
        drive(0, "err_sticky",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000001, 11, 12);
        drive(0, "br_again",    1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7'b1010001, 11, 12);
        drive(0, "wait_again",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1010011, 12, 13);
        drive(0, "rst_mid_bw",  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7'b0000000, 0, 0);
        drive(0, "post_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0);
        // LOAD_LAT=3 with 2-bit counters
        drive(1, "l3_idle",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0);
        drive(1, "l3_lu",       1, 0, 4, 4, 1, 0, 0, 0, 0, 0, 7'b1101000, 0, 0);
        drive(1, "l3_st2",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1101010, 1, 1);
        drive(1, "l3_st3",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1101010, 2, 2);
        drive(1, "l3_run",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 3, 3);
        drive(1, "l3_lu_sat",   1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 7'b1101000, 3, 3);
        drive(1, "l3_st_br",    1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7'b1101010, 3, 3);
        drive(1, "l3_st_sat",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1101010, 3, 3);
        drive(1, "l3_end",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 3, 3);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
